// File: rtl/mul_unit.sv
// Iterative LSB-first shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes on accept; the sign is applied once in FIX.
module full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] result_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             low_half_reg;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   fa_sum;
    logic               fa_cout;
    logic               sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fixed;

    // Partial product: multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    full_adder #(.WIDTH(WIDTH)) u_fa (
        .a    (acc_reg),
        .b    (pp),
        .cin  (1'b0),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // a is signed except for MULHU; b is signed only for MUL/MULH.
    assign sign_a_in = (op != 2'b11) & a[WIDTH-1];
    assign sign_b_in = ~op[1] & b[WIDTH-1];
    assign a_mag     = sign_a_in ? (~a + WIDTH'(1)) : a;
    assign b_mag     = sign_b_in ? (~b + WIDTH'(1)) : b;

    assign prod       = {acc_reg, mplier_reg};
    assign prod_fixed = (sign_a_reg ^ sign_b_reg) ? (~prod + (2*WIDTH)'(1)) : prod;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid)                        state_next = RUN;
            RUN:  if (count_reg == CW'(WIDTH - 1))     state_next = FIX;
            FIX:                                       state_next = DONE;
            DONE: if (out_ready)                       state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            acc_reg      <= '0;
            mplier_reg   <= '0;
            mcand_reg    <= '0;
            result_reg   <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            low_half_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (in_valid) begin
                    count_reg    <= '0;
                    acc_reg      <= '0;
                    mcand_reg    <= a_mag;
                    mplier_reg   <= b_mag;
                    sign_a_reg   <= sign_a_in;
                    sign_b_reg   <= sign_b_in;
                    low_half_reg <= (op == 2'b00);
                end
                RUN: begin
                    acc_reg    <= {fa_cout, fa_sum[WIDTH-1:1]};
                    mplier_reg <= {fa_sum[0], mplier_reg[WIDTH-1:1]};
                    count_reg  <= count_reg + CW'(1);
                end
                FIX: result_reg <= low_half_reg ? prod_fixed[WIDTH-1:0]
                                                : prod_fixed[2*WIDTH-1:WIDTH];
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: driver pushes expected results, a negedge
// monitor pops and compares whenever the unit hands a result off.
`timescale 1ns/1ps
module tb_mul_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    mul_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [W-1:0] res;
        int           acc_cyc;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;
    exp_t exp_q[$];

    bit stall_mode = 1'b0;
    bit rand_stall = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact 64-bit product of the operands as the op interprets them.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy, p;
        sx = (o != 2'b11) ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        sy = (o[1] == 1'b0) ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        p  = sx * sy;
        return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    always @(posedge clk) begin
        #1;
        if (stall_mode)      out_ready = 1'b0;
        else if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
        else                 out_ready = 1'b1;
    end

    // Monitor
    bit           prev_valid = 1'b0;
    bit           handed     = 1'b0;
    logic [W-1:0] prev_result;
    int           n_done = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            handed     = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_while_done", in_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got %h expected none", result);
                end else begin
                    if (!prev_valid)
                        check("latency", cycle - 1 - exp_q[0].acc_cyc, W + 1);
                    else
                        check("hold_stable", result, prev_result);
                    check($sformatf("result op=%0d a=%h b=%h", exp_q[0].op, exp_q[0].a, exp_q[0].b),
                          result, exp_q[0].res);
                end
            end else if (handed) begin
                check("in_ready_after_handoff", in_ready, 1);
            end
            handed = out_valid && out_ready;
            if (handed && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_done++;
            end
            prev_valid  = out_valid;
            prev_result = result;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] expv);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1");
            return;
        end
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        e.res = expv; e.acc_cyc = cycle; e.op = o; e.a = x; e.b = y;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int           guard;
        void'($urandom(32'd20240611));
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", result, 0);

        issue(2'b00, 32'd7, 32'd6, 32'h0000_002A);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_idle();

        // Consumer stall: result must hold for several cycles.
        stall_mode = 1'b1;
        issue(2'b00, 32'd12345, 32'd678, 32'd8369910);
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
        end
        stall_mode = 1'b0;
        wait_idle();

        // New request during RUN is ignored.
        issue(2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();

        // Reset mid-operation aborts it.
        issue(2'b00, 32'd1000, 32'd1000, 32'd1000000);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        issue(2'b00, 32'd3, 32'd5, 32'h0000_000F);
        wait_idle();

        rand_stall = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            issue(ro, ra, rb, ref_mul(ro, ra, rb));
        end
        wait_idle();
        rand_stall = 1'b0;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
